// File: rtl/pool2_bin_if.sv
// Stream bundle between the conv/ReLU stage, the 2x2 pool/binarize stage and its consumer.
// The slave modport is the pooling stage's view.
interface pool2_bin_if;
  logic               start;
  logic               ivalid;
  logic signed [31:0] din;
  logic               idone;
  logic               ovalid;
  logic signed [31:0] dout;
  logic               obit;
  logic               done;
  logic               err;

  modport slave (
    input  start, ivalid, din, idone,
    output ovalid, dout, obit, done, err
  );

  modport master (
    output start, ivalid, din, idone,
    input  ovalid, dout, obit, done, err
  );
endinterface

// File: rtl/pool2_bin.sv
// Streaming 2x2 signed max-pool with threshold binarization.
// A one-row buffer of horizontal pair maxima lets odd rows close each window on the fly.
module pool2_bin #(
  parameter int                 IMG_W  = 24,
  parameter int                 IMG_H  = 24,
  parameter logic signed [31:0] THRESH = 32'sd0
) (
  input  logic        clk,
  input  logic        rst,
  pool2_bin_if.slave  bus
);

  localparam int HALF = IMG_W / 2;
  localparam int NWIN = HALF * (IMG_H / 2);
  localparam int CW   = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int WW   = (NWIN > 1) ? $clog2(NWIN + 1) : 1;

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [WW-1:0] WIN_MAX = WW'(NWIN - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CW-1:0]      r_col;
  logic [RW-1:0]      r_row;
  logic [WW-1:0]      r_win;
  logic signed [31:0] r_hold;
  logic signed [31:0] r_lb_q;
  logic signed [31:0] r_lb [HALF];
  logic               r_last_pend;
  logic               r_ovalid;
  logic signed [31:0] r_dout;
  logic               r_obit;
  logic               r_done;
  logic               r_err;

  logic               w_accept;
  logic               w_last;
  logic               w_short;
  logic               w_emit;
  logic [LW-1:0]      w_lb_idx;
  logic signed [31:0] w_pair;
  logic signed [31:0] w_win;

  // start always wins over a sample or idone presented on the same cycle
  always_comb begin
    w_accept = (r_state == S_RUN) && bus.ivalid && !bus.start;
    w_last   = w_accept && (r_col == COL_MAX) && (r_row == ROW_MAX) && (r_win == WIN_MAX);
    w_short  = (r_state == S_RUN) && bus.idone && !bus.start && !w_last;
    w_emit   = w_accept && r_col[0] && r_row[0];
    w_lb_idx = LW'(r_col >> 1);
    w_pair   = (bus.din > r_hold) ? bus.din : r_hold;
    w_win    = (w_pair > r_lb_q) ? w_pair : r_lb_q;
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.start) begin
      w_state_next = S_RUN;
    end else if ((r_state == S_RUN) && (w_last || w_short)) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.start) begin
      r_col <= '0;
      r_row <= '0;
      r_win <= '0;
    end else if (w_accept) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
      if (w_emit) begin
        r_win <= r_win + 1'b1;
      end
    end
  end

  // Datapath registers carry no reset: every value is written before it is consumed.
  always_ff @(posedge clk) begin
    if (w_accept && !r_col[0]) begin
      r_hold <= bus.din;
      r_lb_q <= r_lb[w_lb_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && r_col[0] && !r_row[0]) begin
      r_lb[w_lb_idx] <= w_pair;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.start) begin
      r_ovalid <= 1'b0;
      r_dout   <= '0;
      r_obit   <= 1'b0;
    end else if (w_emit) begin
      r_ovalid <= 1'b1;
      r_dout   <= w_win;
      r_obit   <= (w_win > THRESH);
    end else begin
      r_ovalid <= 1'b0;
      r_dout   <= '0;
      r_obit   <= 1'b0;
    end
  end

  // Normal completion reports done one cycle after the final window; a short frame reports at once.
  always_ff @(posedge clk) begin
    if (rst || bus.start) begin
      r_last_pend <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_last_pend <= w_last;
      r_done      <= r_last_pend || w_short;
      if (w_short) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.ovalid = r_ovalid;
  assign bus.dout   = r_dout;
  assign bus.obit   = r_obit;
  assign bus.done   = r_done;
  assign bus.err    = r_err;

endmodule

// File: tb/tb_pool2_bin.sv
// Directed bench for pool2_bin: two 4x4 instances (THRESH 5 and 0) and one 24x24 instance.
// A negedge monitor records outputs of the selected instance; checks run in one initial block.
module tb_pool2_bin;

  logic clk;
  logic rst;
  int   cyc;
  int   sel;

  logic               start_r;
  logic               ivalid_r;
  logic               idone_r;
  logic signed [31:0] din_r;

  pool2_bin_if a_if ();
  pool2_bin_if b_if ();
  pool2_bin_if c_if ();

  pool2_bin #(.IMG_W(4),  .IMG_H(4),  .THRESH(32'sd5)) u_a (.clk(clk), .rst(rst), .bus(a_if));
  pool2_bin #(.IMG_W(4),  .IMG_H(4),  .THRESH(32'sd0)) u_b (.clk(clk), .rst(rst), .bus(b_if));
  pool2_bin #(.IMG_W(24), .IMG_H(24), .THRESH(32'sd0)) u_c (.clk(clk), .rst(rst), .bus(c_if));

  assign a_if.start  = start_r  && (sel == 0);
  assign a_if.ivalid = ivalid_r && (sel == 0);
  assign a_if.idone  = idone_r  && (sel == 0);
  assign a_if.din    = din_r;
  assign b_if.start  = start_r  && (sel == 1);
  assign b_if.ivalid = ivalid_r && (sel == 1);
  assign b_if.idone  = idone_r  && (sel == 1);
  assign b_if.din    = din_r;
  assign c_if.start  = start_r  && (sel == 2);
  assign c_if.ivalid = ivalid_r && (sel == 2);
  assign c_if.idone  = idone_r  && (sel == 2);
  assign c_if.din    = din_r;

  logic               m_ovalid;
  logic signed [31:0] m_dout;
  logic               m_obit;
  logic               m_done;
  logic               m_err;

  always_comb begin
    m_ovalid = a_if.ovalid;
    m_dout   = a_if.dout;
    m_obit   = a_if.obit;
    m_done   = a_if.done;
    m_err    = a_if.err;
    if (sel == 1) begin
      m_ovalid = b_if.ovalid;
      m_dout   = b_if.dout;
      m_obit   = b_if.obit;
      m_done   = b_if.done;
      m_err    = b_if.err;
    end else if (sel == 2) begin
      m_ovalid = c_if.ovalid;
      m_dout   = c_if.dout;
      m_obit   = c_if.obit;
      m_done   = c_if.done;
      m_err    = c_if.err;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic               mon_en;
  logic signed [31:0] q_val [$];
  logic               q_bit [$];
  int                 q_cyc [$];
  int                 q_drv [$];
  int                 done_cnt;
  int                 done_cyc;
  int                 idle_bad;
  int                 idone_cyc;

  always @(negedge clk) begin
    if (mon_en) begin
      if (m_ovalid === 1'b1) begin
        q_val.push_back(m_dout);
        q_bit.push_back(m_obit);
        q_cyc.push_back(cyc);
      end else if (m_dout !== 32'sd0 || m_obit !== 1'b0) begin
        idle_bad++;
      end
      if (m_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    q_val.delete();
    q_bit.delete();
    q_cyc.delete();
    q_drv.delete();
    done_cnt = 0;
    done_cyc = -1;
    idle_bad = 0;
  endtask

  task automatic step_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      start_r  = 1'b0;
      ivalid_r = 1'b0;
      idone_r  = 1'b0;
    end
  endtask

  task automatic send(input logic signed [31:0] v);
    @(posedge clk); #1;
    start_r  = 1'b0;
    idone_r  = 1'b0;
    ivalid_r = 1'b1;
    din_r    = v;
    q_drv.push_back(cyc);
  endtask

  task automatic pulse_start(input logic with_sample);
    @(posedge clk); #1;
    start_r  = 1'b1;
    idone_r  = 1'b0;
    ivalid_r = with_sample;
    din_r    = 32'sd100;
  endtask

  task automatic pulse_idone();
    @(posedge clk); #1;
    start_r   = 1'b0;
    ivalid_r  = 1'b0;
    idone_r   = 1'b1;
    idone_cyc = cyc;
  endtask

  // Checks the four windows of a 4x4 frame; trig holds the sample indices that close each window.
  task automatic chk_frame4(input string tag, input logic signed [31:0] e0, input logic signed [31:0] e1,
                            input logic signed [31:0] e2, input logic signed [31:0] e3,
                            input logic [3:0] ebits, input int tofs);
    logic signed [31:0] ev [4];
    int trig [4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    trig[0] = 5 + tofs; trig[1] = 7 + tofs; trig[2] = 13 + tofs; trig[3] = 15 + tofs;
    chk({tag, "_count"}, q_val.size(), 4);
    if (q_val.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s_dout%0d", tag, i), q_val[i], ev[i]);
        chk($sformatf("%s_obit%0d", tag, i), q_bit[i], ebits[i]);
        chk($sformatf("%s_lat%0d", tag, i), q_cyc[i], q_drv[trig[i]] + 1);
      end
      chk({tag, "_done_cyc"}, done_cyc, q_cyc[3] + 1);
    end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_err"}, m_err, 0);
    chk({tag, "_idle_zero"}, idle_bad, 0);
  endtask

  logic signed [31:0] img [576];
  logic signed [31:0] ref_v;

  initial begin
    sel      = 0;
    mon_en   = 1'b0;
    start_r  = 1'b0;
    ivalid_r = 1'b0;
    idone_r  = 1'b0;
    din_r    = '0;
    rst      = 1'b1;
    clr_mon();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ovalid", a_if.ovalid, 0);
    chk("rst_dout",   a_if.dout,   0);
    chk("rst_obit",   a_if.obit,   0);
    chk("rst_done",   a_if.done,   0);
    chk("rst_err",    a_if.err,    0);
    mon_en = 1'b1;

    // Samples in IDLE must be ignored.
    clr_mon();
    for (int i = 0; i < 16; i++) send(i);
    step_idle(3);
    chk("idle_ignore_cnt", q_val.size(), 0);
    chk("idle_ignore_done", done_cnt, 0);

    // 0..15 at full rate, THRESH 5.
    pulse_start(1'b0);
    clr_mon();
    for (int i = 0; i < 16; i++) send(i);
    step_idle(4);
    chk_frame4("full", 5, 7, 13, 15, 4'b1110, 0);

    // Signed frame on the THRESH 0 instance.
    sel = 1;
    pulse_start(1'b0);
    clr_mon();
    for (int i = 0; i < 16; i++) send(i - 16);
    step_idle(4);
    chk_frame4("neg", -11, -9, -3, -1, 4'b0000, 0);

    // Gapped input stream.
    sel = 0;
    pulse_start(1'b0);
    clr_mon();
    for (int i = 0; i < 16; i++) begin
      send(i);
      step_idle(1);
    end
    step_idle(3);
    chk_frame4("gap", 5, 7, 13, 15, 4'b1110, 0);

    // Short frame: 10 samples then idone.
    pulse_start(1'b0);
    clr_mon();
    for (int i = 0; i < 10; i++) send(i);
    pulse_idone();
    step_idle(3);
    chk("short_count", q_val.size(), 2);
    if (q_val.size() == 2) begin
      chk("short_dout0", q_val[0], 5);
      chk("short_dout1", q_val[1], 7);
    end
    chk("short_done_cnt", done_cnt, 1);
    chk("short_done_cyc", done_cyc, idone_cyc + 1);
    chk("short_err", m_err, 1);
    for (int i = 10; i < 16; i++) send(i);
    step_idle(3);
    chk("short_no_more", q_val.size(), 2);
    chk("short_err_sticky", m_err, 1);
    chk("short_done_once", done_cnt, 1);

    // Restart mid-frame; the sample presented with start is dropped.
    pulse_start(1'b0);
    step_idle(1);
    chk("restart_err_clr", m_err, 0);
    clr_mon();
    for (int i = 0; i < 7; i++) send(i + 40);
    pulse_start(1'b1);
    clr_mon();
    for (int i = 0; i < 16; i++) send(i);
    step_idle(4);
    chk_frame4("restart", 5, 7, 13, 15, 4'b1110, 0);

    // Reset mid-frame aborts with no done and no further outputs.
    pulse_start(1'b0);
    for (int i = 0; i < 5; i++) send(i);
    @(posedge clk); #1;
    ivalid_r = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clr_mon();
    for (int i = 5; i < 16; i++) send(i);
    step_idle(4);
    chk("rst_mid_count", q_val.size(), 0);
    chk("rst_mid_done", done_cnt, 0);
    chk("rst_mid_idle_zero", idle_bad, 0);

    // 24x24 random non-negative frame against a reference 2x2 max.
    sel = 2;
    for (int i = 0; i < 576; i++) img[i] = $signed({1'b0, 31'($urandom)});
    pulse_start(1'b0);
    clr_mon();
    for (int i = 0; i < 576; i++) send(img[i]);
    step_idle(4);
    chk("big_count", q_val.size(), 144);
    if (q_val.size() == 144) begin
      for (int wr = 0; wr < 12; wr++) begin
        for (int wc = 0; wc < 12; wc++) begin
          int b;
          b = (2 * wr) * 24 + 2 * wc;
          ref_v = img[b];
          if (img[b + 1]  > ref_v) ref_v = img[b + 1];
          if (img[b + 24] > ref_v) ref_v = img[b + 24];
          if (img[b + 25] > ref_v) ref_v = img[b + 25];
          chk($sformatf("big_dout%0d", wr * 12 + wc), q_val[wr * 12 + wc], ref_v);
          chk($sformatf("big_obit%0d", wr * 12 + wc), q_bit[wr * 12 + wc], (ref_v > 0) ? 1 : 0);
        end
      end
      chk("big_done_cyc", done_cyc, q_cyc[143] + 1);
    end
    chk("big_done_cnt", done_cnt, 1);
    chk("big_err", m_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
